// File: rtl/unidade_saida_pkg.sv
// Shared definitions for the CPU output unit: FSM states, 7-segment table
// and the per-nibble double-dabble adjust.
package pacote_saida;

  typedef enum logic {
    OCIOSO   = 1'b0,
    CONVERTE = 1'b1
  } estado_t;

  // Active-high gfedcba pattern meaning "everything off".
  localparam logic [6:0] SEG_APAGADO = 7'b0000000;

  // Digit -> gfedcba, active-high. Entry 0 sits in the low bits.
  // A-F are blank because only BCD digits ever reach the table.
  localparam logic [15:0][6:0] TABELA_7SEG = {
    7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,  // F..A
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,         // 9..5
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F          // 4..0
  };

  // Double-dabble step: a nibble >= 5 gets +3 (4-bit, carry dropped).
  function automatic logic [3:0] ajusta_bcd(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/unidade_saida_if.sv
// Control <-> output unit bus. master = CPU control, slave = unidade_saida.
interface unidade_saida_if #(
  parameter int LARGURA = 16,
  parameter int DIGITOS = 5
);
  logic                   imprimir;
  logic [LARGURA-1:0]     valor;
  logic                   ocupado;
  logic                   pronto;
  logic [4*DIGITOS-1:0]   bcd;
  logic [7*DIGITOS-1:0]   segmentos;
  logic                   sinal;

  modport master (
    output imprimir, valor,
    input  ocupado, pronto, bcd, segmentos, sinal
  );

  modport slave (
    input  imprimir, valor,
    output ocupado, pronto, bcd, segmentos, sinal
  );
endinterface

// File: rtl/unidade_saida_conversor_7seg.sv
// Combinational nibble -> 7-segment decoder with output polarity select.
// apagar_i forces the digit dark regardless of the nibble.
module conversor_7seg
  import pacote_saida::*;
#(
  parameter bit ATIVO_BAIXO = 1'b1
) (
  input  logic [3:0] digito_i,
  input  logic       apagar_i,
  output logic [6:0] segmentos_o
);
  logic [6:0] seg_alto;

  assign seg_alto    = apagar_i ? SEG_APAGADO : TABELA_7SEG[digito_i];
  assign segmentos_o = ATIVO_BAIXO ? ~seg_alto : seg_alto;
endmodule

// File: rtl/unidade_saida.sv
// Output unit: serial double-dabble binary->BCD, one bit per clock, then
// registered BCD and 7-segment digits. Define SINAL_EN to treat valor as
// two's-complement (magnitude displayed, sign on `sinal`).
module unidade_saida
  import pacote_saida::*;
#(
  parameter int LARGURA         = 16,
  parameter int DIGITOS         = 5,
  parameter bit SEG_ATIVO_BAIXO = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  unidade_saida_if.slave  io
);
  localparam int CW = $clog2(LARGURA + 1);
  localparam int AW = 4 * DIGITOS;

  estado_t           estado_q, estado_d;
  logic [CW-1:0]     contador_q, contador_d;
  logic [LARGURA-1:0] shift_q, shift_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [AW-1:0]     bcd_q, bcd_d;
  logic              pronto_q, pronto_d;
  logic              valido_q, valido_d;   // a result has been shown since reset
  logic              sinal_q, sinal_d;
  logic              sinal_pend_q, sinal_pend_d;

  logic [LARGURA-1:0] valor_abs;
  logic               negativo;
  logic [AW-1:0]      acc_aj;
  logic [AW+LARGURA-1:0] desloc;
  logic [7*DIGITOS-1:0]  seg;

`ifdef SINAL_EN
  // Magnitude as LARGURA-bit unsigned: the most negative value maps onto
  // its own bit pattern, which reads correctly as unsigned.
  assign negativo  = io.valor[LARGURA-1];
  assign valor_abs = negativo ? (~io.valor + LARGURA'(1)) : io.valor;
`else
  assign negativo  = 1'b0;
  assign valor_abs = io.valor;
`endif

  // Per-nibble +3 ahead of each shift.
  for (genvar g = 0; g < DIGITOS; g++) begin : g_ajuste
    assign acc_aj[4*g +: 4] = ajusta_bcd(acc_q[4*g +: 4]);
  end

  assign desloc = {acc_aj, shift_q} << 1;

  // Next-state: accept in OCIOSO, one dabble step per edge in CONVERTE,
  // publish the result on the last step.
  always_comb begin
    estado_d     = estado_q;
    contador_d   = contador_q;
    shift_d      = shift_q;
    acc_d        = acc_q;
    bcd_d        = bcd_q;
    pronto_d     = 1'b0;
    valido_d     = valido_q;
    sinal_d      = sinal_q;
    sinal_pend_d = sinal_pend_q;
    case (estado_q)
      OCIOSO: begin
        if (io.imprimir) begin
          shift_d      = valor_abs;
          acc_d        = '0;
          contador_d   = CW'(LARGURA);
          sinal_pend_d = negativo;
          estado_d     = CONVERTE;
        end
      end
      CONVERTE: begin
        acc_d      = desloc[AW+LARGURA-1:LARGURA];
        shift_d    = desloc[LARGURA-1:0];
        contador_d = contador_q - CW'(1);
        if (contador_q == CW'(1)) begin
          estado_d = OCIOSO;
          bcd_d    = desloc[AW+LARGURA-1:LARGURA];
          sinal_d  = sinal_pend_q;
          valido_d = 1'b1;
          pronto_d = 1'b1;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // State and result registers; reset aborts any conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q     <= OCIOSO;
      contador_q   <= '0;
      shift_q      <= '0;
      acc_q        <= '0;
      bcd_q        <= '0;
      pronto_q     <= 1'b0;
      valido_q     <= 1'b0;
      sinal_q      <= 1'b0;
      sinal_pend_q <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      contador_q   <= contador_d;
      shift_q      <= shift_d;
      acc_q        <= acc_d;
      bcd_q        <= bcd_d;
      pronto_q     <= pronto_d;
      valido_q     <= valido_d;
      sinal_q      <= sinal_d;
      sinal_pend_q <= sinal_pend_d;
    end
  end

  // One decoder per digit, driven from the registered BCD; dark until the
  // first result so reset shows nothing rather than zeros.
  for (genvar g = 0; g < DIGITOS; g++) begin : g_digito
    conversor_7seg #(.ATIVO_BAIXO(SEG_ATIVO_BAIXO)) u_conv (
      .digito_i    (bcd_q[4*g +: 4]),
      .apagar_i    (!valido_q),
      .segmentos_o (seg[7*g +: 7])
    );
  end

  assign io.ocupado   = (estado_q == CONVERTE);
  assign io.pronto    = pronto_q;
  assign io.bcd       = bcd_q;
  assign io.segmentos = seg;
  assign io.sinal     = sinal_q;
endmodule

// File: tb/tb_unidade_saida.sv
// Directed bench for unidade_saida: reset, conversions, latency, overlap,
// reset mid-run and (with SINAL_EN) signed inputs.
module tb_unidade_saida;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  unidade_saida_if #(.LARGURA(16), .DIGITOS(5)) bus ();

  unidade_saida #(
    .LARGURA(16), .DIGITOS(5), .SEG_ATIVO_BAIXO(1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [34:0] SEG_TODOS_OFF = 35'h7_FFFF_FFFF;
  localparam logic [6:0]  SEG_0 = 7'b1000000;
  localparam logic [6:0]  SEG_1 = 7'b1111001;
  localparam logic [6:0]  SEG_5 = 7'b0010010;

`ifdef SINAL_EN
  localparam logic [19:0] ESP_FFFF   = 20'h00001;
  localparam logic        ESP_SINAL_FFFF = 1'b1;
`else
  localparam logic [19:0] ESP_FFFF   = 20'h65535;
  localparam logic        ESP_SINAL_FFFF = 1'b0;
`endif

  task automatic verifica(input string tag, input logic [63:0] obs, input logic [63:0] esp);
    n_chk++;
    if (obs !== esp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a one-cycle request; returns just after the sampling edge.
  task automatic pede(input logic [15:0] v);
    bus.valor    = v;
    bus.imprimir = 1'b1;
    tick();
    bus.imprimir = 1'b0;
  endtask

  // Edges until pronto, and how many sampled cycles had ocupado high.
  task automatic espera_pronto(output int lat, output int occ);
    lat = 0;
    occ = 0;
    while (bus.pronto !== 1'b1 && lat < 40) begin
      if (bus.ocupado === 1'b1) occ++;
      tick();
      lat++;
    end
  endtask

  int lat, occ;
  logic visto;

  initial begin
    bus.imprimir = 1'b0;
    bus.valor    = '0;
    #12;
    verifica("rst_ocupado",   bus.ocupado,   1'b0);
    verifica("rst_pronto",    bus.pronto,    1'b0);
    verifica("rst_bcd",       bus.bcd,       20'h0);
    verifica("rst_segmentos", bus.segmentos, SEG_TODOS_OFF);
    verifica("rst_sinal",     bus.sinal,     1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // 12345: outputs hold old value mid-run, 16 cycles busy
    pede(16'd12345);
    verifica("12345_ocupado_ini", bus.ocupado, 1'b1);
    repeat (8) tick();
    verifica("12345_hold_bcd", bus.bcd, 20'h0);
    verifica("12345_hold_seg", bus.segmentos, SEG_TODOS_OFF);
    verifica("12345_pronto_cedo", bus.pronto, 1'b0);
    espera_pronto(lat, occ);
    verifica("12345_lat_resto", lat, 8);
    verifica("12345_occ_resto", occ, 8);
    verifica("12345_ocupado_fim", bus.ocupado, 1'b0);
    verifica("12345_bcd", bus.bcd, 20'h12345);
    verifica("12345_dig0", bus.segmentos[6:0], SEG_5);
    verifica("12345_dig4", bus.segmentos[34:28], SEG_1);
    verifica("12345_sinal", bus.sinal, 1'b0);
    tick();
    verifica("12345_pronto_pulso", bus.pronto, 1'b0);

    // valor = 0
    pede(16'd0);
    espera_pronto(lat, occ);
    verifica("zero_lat", lat, 16);
    verifica("zero_occ", occ, 16);
    verifica("zero_bcd", bus.bcd, 20'h0);
    verifica("zero_seg", bus.segmentos, {5{SEG_0}});
    tick();

    // valor = 65535 (or -1 when signed)
    pede(16'hFFFF);
    espera_pronto(lat, occ);
    verifica("max_lat", lat, 16);
    verifica("max_bcd", bus.bcd, ESP_FFFF);
    verifica("max_sinal", bus.sinal, ESP_SINAL_FFFF);
    tick();

    // Overlap: request while busy is dropped
    pede(16'd100);
    repeat (3) tick();
    pede(16'd7);
    espera_pronto(lat, occ);
    verifica("ovl_lat", lat, 12);
    verifica("ovl_bcd", bus.bcd, 20'h00100);
    // Request in the pronto cycle is taken
    pede(16'd7);
    verifica("b2b_ocupado", bus.ocupado, 1'b1);
    verifica("b2b_hold_bcd", bus.bcd, 20'h00100);
    espera_pronto(lat, occ);
    verifica("b2b_lat", lat, 16);
    verifica("b2b_bcd", bus.bcd, 20'h00007);
    tick();

    // Reset in the middle of a conversion
    pede(16'd999);
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    verifica("mid_rst_ocupado", bus.ocupado, 1'b0);
    verifica("mid_rst_pronto",  bus.pronto,  1'b0);
    verifica("mid_rst_bcd",     bus.bcd,     20'h0);
    verifica("mid_rst_seg",     bus.segmentos, SEG_TODOS_OFF);
    tick();
    tick();
    rst_n = 1'b1;
    visto = 1'b0;
    repeat (30) begin
      tick();
      if (bus.pronto === 1'b1) visto = 1'b1;
    end
    verifica("mid_rst_sem_pronto", visto, 1'b0);
    verifica("mid_rst_bcd_final", bus.bcd, 20'h0);

`ifdef SINAL_EN
    pede(16'hFFFF);
    espera_pronto(lat, occ);
    verifica("s_m1_bcd", bus.bcd, 20'h00001);
    verifica("s_m1_sinal", bus.sinal, 1'b1);
    tick();
    pede(16'h8000);
    espera_pronto(lat, occ);
    verifica("s_min_bcd", bus.bcd, 20'h32768);
    verifica("s_min_sinal", bus.sinal, 1'b1);
    tick();
    pede(16'd42);
    espera_pronto(lat, occ);
    verifica("s_pos_bcd", bus.bcd, 20'h00042);
    verifica("s_pos_sinal", bus.sinal, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
